// File: rtl/gpio_debounce_pkg.sv
// Shared constants for the GPIO debouncer: pending-event source encodings
// and the default stability window (1 ms at 100 MHz).
package gpio_pkg;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  localparam int unsigned DEB_CYCLES_DEFAULT = 100000;

endpackage

// File: rtl/gpio_debounce_ch.sv
// One debounced channel: 2-flop synchroniser, stability counter, level
// register and registered rise/fall pulses.
module debounce_ch #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter logic        INV        = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_in;
  logic          w_diff;
  logic          w_accept;

  // Inverting ahead of the flops lets the reset value 0 mean "inactive",
  // so an active-low pin held pressed through reset is seen as a new change.
  assign w_in     = i_raw ^ INV;
  assign w_diff   = r_sync != r_level;
  assign w_accept = w_diff && (r_cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= w_in;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync;
        r_rise  <= r_sync;
        r_fall  <= ~r_sync;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/gpio_debounce.sv
// Multi-channel GPIO debouncer with edge-latched pending flags and a level irq.
// Pending/irq logic is built only when GPIO_DEBOUNCE_IRQ_EN is defined.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned     N_CH       = 4,
  parameter int unsigned     DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter logic [N_CH-1:0] INV_MASK   = '0,
  parameter int unsigned     EDGE_MODE  = EDGE_RISE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  input  logic [N_CH-1:0] clr,
  input  logic [N_CH-1:0] irq_mask,
  output logic [N_CH-1:0] pending,
  output logic            irq
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .INV       (INV_MASK[g])
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .i_raw  (raw_in[g]),
      .o_level(level[g]),
      .o_rise (rise[g]),
      .o_fall (fall[g])
    );
  end

`ifdef GPIO_DEBOUNCE_IRQ_EN
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] w_set;
  logic            r_irq;

  always_comb begin
    w_set = rise;
    if (EDGE_MODE == EDGE_FALL)      w_set = fall;
    else if (EDGE_MODE == EDGE_BOTH) w_set = rise | fall;
  end

  // A new event wins over a simultaneous clear so no edge is ever lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~clr) | w_set;
      r_irq     <= |(r_pending & irq_mask);
    end
  end

  assign pending = r_pending;
  assign irq     = r_irq;
`else
  logic w_unused;
  assign w_unused = ^{clr, irq_mask};
  assign pending  = '0;
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce (N_CH=4, DEB_CYCLES=4, INV_MASK=0001, rise mode).
module tb_gpio_debounce;
  import gpio_pkg::*;

`ifdef GPIO_DEBOUNCE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] raw_in;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] clr;
  logic [3:0] irq_mask;
  logic [3:0] pending;
  logic       irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpio_debounce #(
    .N_CH      (4),
    .DEB_CYCLES(4),
    .INV_MASK  (4'b0001),
    .EDGE_MODE (EDGE_RISE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_in  (raw_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .clr     (clr),
    .irq_mask(irq_mask),
    .pending (pending),
    .irq     (irq)
  );

  typedef struct {
    logic [3:0] raw;
    logic [3:0] clr;
    logic       rst_n;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] pend;
    logic       irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [3:0] raw, input logic [3:0] c,
                     input logic rst_n, input logic [3:0] lvl, input logic [3:0] ri,
                     input logic [3:0] fa, input logic [3:0] pe, input logic iq);
    vec_t v;
    v.raw = raw; v.clr = c; v.rst_n = rst_n; v.lvl = lvl;
    v.rise = ri; v.fall = fa; v.pend = pe; v.irq = iq;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%b exp=%b", name, row, act, exp);
    end
  endtask

  // Pending/irq expectations collapse to 0 when the interrupt logic is not built.
  task automatic chk_all(input int row, input logic [3:0] lvl, input logic [3:0] ri,
                         input logic [3:0] fa, input logic [3:0] pe, input logic iq);
    chk("level", row, level, lvl);
    chk("rise", row, rise, ri);
    chk("fall", row, fall, fa);
    chk("pending", row, pending, IRQ_EN ? pe : 4'b0000);
    chk("irq", row, {3'b000, irq}, {3'b000, IRQ_EN ? iq : 1'b0});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    raw_in   = 4'b0000;
    clr      = 4'b0000;
    irq_mask = 4'b0010;

    // raw, clr, rst_n -> level, rise, fall, pending, irq (after the edge)
    add(2, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); // reset, ch0 pressed (active-low)
    add(5, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    add(1, 4'h0, 4'h0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0); // edge 6: ch0 accepted
    add(1, 4'h0, 4'h0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);
    add(1, 4'h0, 4'h1, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    add(5, 4'h2, 4'h0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0); // ch1 goes high
    add(1, 4'h2, 4'h0, 1'b1, 4'h3, 4'h2, 4'h0, 4'h0, 1'b0);
    add(1, 4'h2, 4'h0, 1'b1, 4'h3, 4'h0, 4'h0, 4'h2, 1'b0);
    add(2, 4'h2, 4'h0, 1'b1, 4'h3, 4'h0, 4'h0, 4'h2, 1'b1);
    add(3, 4'h6, 4'h0, 1'b1, 4'h3, 4'h0, 4'h0, 4'h2, 1'b1); // ch2 glitch, 3 cycles
    add(4, 4'h2, 4'h0, 1'b1, 4'h3, 4'h0, 4'h0, 4'h2, 1'b1);
    add(1, 4'h0, 4'h0, 1'b1, 4'h3, 4'h0, 4'h0, 4'h2, 1'b1); // ch1 released
    add(1, 4'h0, 4'h2, 1'b1, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1);
    add(3, 4'h0, 4'h0, 1'b1, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0);
    add(1, 4'h0, 4'h0, 1'b1, 4'h1, 4'h0, 4'h2, 4'h0, 1'b0);
    add(5, 4'h2, 4'h0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0); // ch1 pressed again
    add(1, 4'h2, 4'h0, 1'b1, 4'h3, 4'h2, 4'h0, 4'h0, 1'b0);
    add(1, 4'h2, 4'h2, 1'b1, 4'h3, 4'h0, 4'h0, 4'h2, 1'b0); // clr with rise: set wins
    add(1, 4'h2, 4'h0, 1'b1, 4'h3, 4'h0, 4'h0, 4'h2, 1'b1);
    add(1, 4'h2, 4'h2, 1'b1, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1); // lone clr
    add(1, 4'h2, 4'h0, 1'b1, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0);

    for (int r = 0; r < vecs.size(); r++) begin
      raw_in  = vecs[r].raw;
      clr     = vecs[r].clr;
      reset_n = vecs[r].rst_n;
      step();
      chk_all(r, vecs[r].lvl, vecs[r].rise, vecs[r].fall, vecs[r].pend, vecs[r].irq);
    end

    // Reset during count 3 of a pending ch3 change discards it completely.
    raw_in = 4'b1010;
    clr    = 4'b0000;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk_all(100 + e, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0);
    end
    reset_n = 1'b0;
    step();
    chk_all(106, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    reset_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk_all(200 + e, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    end
    step();
    chk_all(206, 4'hB, 4'hB, 4'h0, 4'h0, 1'b0);
    step();
    chk_all(207, 4'hB, 4'h0, 4'h0, 4'hB, 1'b0);
    step();
    chk_all(208, 4'hB, 4'h0, 4'h0, 4'hB, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
